bsg_manycore_npa_to_eva: RTL
============================

// Module: bsg_manycore_npa_to_eva
// PURPOSE
//  Reverse translator: maps a Network Physical Address (x,y,EPA) back to the 32-bit EVA that a vanilla core would issue.
//  Inverts the team's DRAM striping for vcache targets and encodes in-pod tiles as global EVAs.
//  Two-stage valid/ready pipeline. Used by trace/profiling logic and host-side debug snoopers on the network edge.
// PARAMETERS
//  addr_width_p                  28  EPA width (word address)
//  x_cord_width_p                 7  global x cord width = pod_x_cord_width_p + x subcord width
//  y_cord_width_p                 7  global y cord width = pod_y_cord_width_p + y subcord width
//  pod_x_cord_width_p             3  pod x index width
//  pod_y_cord_width_p             4  pod y index width
//  num_tiles_x_p                 16  tiles per pod in x; xs=clog2
//  num_tiles_y_p                  8  tiles per pod in y; ys=clog2
//  num_vcache_rows_p              1  vcache rows on each of north and south; rw=clog2(2*rows)
//  vcache_block_size_in_words_p   8  words per cache line; wo=clog2
// PORTS
//  clk_i            in   1   clock
//  reset_i          in   1   async active-high reset
//  v_i              in   1   request valid
//  ready_o          out  1   request accepted when v_i&ready_o
//  x_cord_i         in   x_cord_width_p  destination x
//  y_cord_i         in   y_cord_width_p  destination y
//  epa_i            in   addr_width_p    endpoint word address
//  pod_x_i          in   pod_x_cord_width_p  pod of interest; sampled with request
//  pod_y_i          in   pod_y_cord_width_p  pod of interest; sampled with request
//  v_o              out  1   result valid
//  yumi_i           in   1   result consumed; only legal while v_o=1
//  eva_o            out  32  reconstructed byte EVA
//  kind_o           out  2   0=DRAM, 1=global, 3=invalid
//  invalid_count_o  out  16  saturating count of invalid results consumed
// BEHAVIOUR
//  Reset: v_o=0, ready_o=1, eva_o=0, kind_o=0, invalid_count_o=0. Reset mid-operation drops all in-flight entries.
//  Latency: 2 cycles from accept to v_o when unstalled. Throughput: 1/cycle.
//  S1 (decode) registers its class and fields. S2 (assemble) is the output register.
//  Each stage advances when it is empty or its downstream takes. ready_o = ~s1_v | s1_adv.
//  Stalling: a stalled S2 holds eva_o/kind_o stable until yumi_i. No entry is dropped or duplicated.
//  Classification uses base = {pod_y_i, ys'(0)}, px = x_cord_i[x_cord_width_p-1 -: pod_x_cord_width_p], xsub = low xs bits.
//   North row k (k<rows): y == base-1-k -> row_id = 2k.
//   South row k: y == base+num_tiles_y_p+k -> row_id = 2k+1.
//   In-pod tile: base <= y < base+num_tiles_y_p.
//   Anything else, or px != pod_x_i -> invalid.
//  DRAM (kind 0): epa_i = {hi, off[wo-1:0]}.
//   eva_o = {1'b1, hi, row_id[rw-1:0], xsub[xs-1:0], off, 2'b00}, truncated to 32 bits.
//   Nonzero hi bits lost in truncation -> invalid.
//  Global (kind 1): eva_o is bsg_manycore_global_addr_s with remote=2'b01, x_cord, y_cord and addr=epa.
//   Invalid if the coordinates or the EPA exceed the package field widths.
//  Invalid (kind 3): eva_o=0.
//  invalid_count_o increments on v_o&yumi_i&kind==3 and saturates at 16'hFFFF.
//  All arithmetic is unsigned at y_cord_width_p+1 bits. base-1-k below 0 never matches (pod_y_i=0 has no north row).
// STRUCTURE
//  bsg_manycore_pkg: add the kind enum (bsg_manycore_npa_kind_e) and reuse global_addr_s and its width constants.
//  One sub-module: bsg_manycore_dram_hash_inverse, a combinational function of (row_id, xsub, epa) to DRAM EVA.
//   It is the exact inverse of the team's DRAM hash.
//  Stage registers use bsg_dff_reset_en. Pipeline control is inline.
// TESTING  (defaults, pod_x_i=1, pod_y_i=1 -> base y=8)
//  1 North: x=21, y=7, epa=0x123 -> after 2 cycles v_o=1, kind=0, eva_o=0x800090AC.
//  2 South: x=21, y=16, epa=0x123 -> kind=0, eva_o=0x800092AC.
//  3 Tile: x=21, y=9, epa=0x40 -> kind=1, eva_o decodes to remote=01, y=9, x=21, addr=0x40.
//  4 Invalid: x=5 (pod 0) or y=30 -> kind=3, eva_o=0; invalid_count_o increments per consume; forcing 0xFFFF holds.
//  5 Backpressure: 6 back-to-back requests, yumi_i low 4 cycles.
//   ready_o drops after 2 are held; outputs stay stable. In-order delivery; no loss or duplication.
//  6 Reset mid-flight: assert reset_i with 2 entries in flight.
//   v_o=0 the same cycle; after release ready_o=1 and no stale output appears.

Source files
------------

// File: rtl/bsg_manycore_pkg.sv
// Shared manycore address formats plus the result kind reported by the NPA-to-EVA translator.
package bsg_manycore_pkg;

   localparam int global_epa_word_addr_width_gp = 14;
   localparam int max_global_x_cord_width_gp    = 7;
   localparam int max_global_y_cord_width_gp    = 7;

   // Byte EVA a core issues to reach any tile in the mesh.
   typedef struct packed {
      logic [1:0]                               remote;
      logic [max_global_y_cord_width_gp-1:0]    y_cord;
      logic [max_global_x_cord_width_gp-1:0]    x_cord;
      logic [global_epa_word_addr_width_gp-1:0] addr;
      logic [1:0]                               low_bits;
   } bsg_manycore_global_addr_s;

   typedef enum logic [1:0] {
      e_npa_dram    = 2'd0,
      e_npa_global  = 2'd1,
      e_npa_invalid = 2'd3
   } bsg_manycore_npa_kind_e;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with asynchronous active-high reset to zero.
module bsg_dff_reset_en #(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         data_o <= '0;
      else if (en_i)
         data_o <= data_i;
   end

endmodule

// File: rtl/bsg_manycore_dram_hash_inverse.sv
// Undoes the DRAM striping: rebuilds the DRAM EVA from the vcache row, the x subcord and the cache EPA.
module bsg_manycore_dram_hash_inverse #(
   parameter int addr_width_p         = 28,
   parameter int row_width_p          = 1,
   parameter int xsub_width_p         = 4,
   parameter int block_offset_width_p = 3
) (
   input  logic [row_width_p-1:0]  row_id_i,
   input  logic [xsub_width_p-1:0] xsub_i,
   input  logic [addr_width_p-1:0] epa_i,
   output logic [31:0]             eva_o,
   output logic                    overflow_o
);

   localparam int low_width_lp    = row_width_p + xsub_width_p + block_offset_width_p + 2;
   localparam int eva_hi_width_lp = 31 - low_width_lp;
   localparam int hi_width_lp     = addr_width_p - block_offset_width_p;

   logic [hi_width_lp-1:0]          hi;
   logic [block_offset_width_p-1:0] off;

   assign {hi, off} = epa_i;

   // Bit 31 marks DRAM space; the line index sits above the bank select (row, x).
   assign eva_o      = {1'b1, eva_hi_width_lp'(hi), row_id_i, xsub_i, off, 2'b00};
   assign overflow_o = (hi >> eva_hi_width_lp) != '0;

endmodule

// File: rtl/bsg_manycore_npa_to_eva.sv
// Reverse translator from a network physical address (x, y, EPA) to the 32-bit EVA a core would issue.
module bsg_manycore_npa_to_eva
   import bsg_manycore_pkg::*;
#(
   parameter int addr_width_p                 = 28,
   parameter int x_cord_width_p               = 7,
   parameter int y_cord_width_p               = 7,
   parameter int pod_x_cord_width_p           = 3,
   parameter int pod_y_cord_width_p           = 4,
   parameter int num_tiles_x_p                = 16,
   parameter int num_tiles_y_p                = 8,
   parameter int num_vcache_rows_p            = 1,
   parameter int vcache_block_size_in_words_p = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          v_i,
   output logic                          ready_o,
   input  logic [x_cord_width_p-1:0]     x_cord_i,
   input  logic [y_cord_width_p-1:0]     y_cord_i,
   input  logic [addr_width_p-1:0]       epa_i,
   input  logic [pod_x_cord_width_p-1:0] pod_x_i,
   input  logic [pod_y_cord_width_p-1:0] pod_y_i,
   output logic                          v_o,
   input  logic                          yumi_i,
   output logic [31:0]                   eva_o,
   output logic [1:0]                    kind_o,
   output logic [15:0]                   invalid_count_o
);

   localparam int xs_lp       = $clog2(num_tiles_x_p);
   localparam int ys_lp       = $clog2(num_tiles_y_p);
   localparam int rw_lp       = $clog2(2*num_vcache_rows_p);
   localparam int wo_lp       = $clog2(vcache_block_size_in_words_p);
   localparam int s1_width_lp = 2 + rw_lp + xs_lp + x_cord_width_p + y_cord_width_p + addr_width_p;
   localparam int s2_width_lp = 2 + 32;

   typedef logic [y_cord_width_p:0] ycalc_t;
   typedef logic [rw_lp-1:0]        row_t;

   // Handshake: a request transfers on a clock edge with v_i & ready_o; a result leaves with
   // v_o & yumi_i, and yumi_i may only be raised while v_o is high.
   logic s1_v, s2_v, s2_adv;

   assign s2_adv  = ~s2_v | yumi_i;
   assign ready_o = ~s1_v | s2_adv;
   assign v_o     = s2_v;

   ycalc_t                        y_ext, base;
   logic [pod_x_cord_width_p-1:0] px;
   logic [xs_lp-1:0]              xsub;
   logic                          is_dram, is_tile;
   row_t                          row_id;
   bsg_manycore_npa_kind_e        kind_d;

   assign y_ext = ycalc_t'(y_cord_i);
   assign base  = ycalc_t'({pod_y_i, {ys_lp{1'b0}}});
   assign px    = x_cord_i[x_cord_width_p-1 -: pod_x_cord_width_p];
   assign xsub  = x_cord_i[xs_lp-1:0];

   // One extra bit of y arithmetic keeps the south rows of the top pod from wrapping onto tiles.
   always_comb begin
      is_dram = 1'b0;
      row_id  = '0;
      for (int k = 0; k < num_vcache_rows_p; k++) begin
         if ((base > ycalc_t'(k)) && (y_ext == base - ycalc_t'(k + 1))) begin
            is_dram = 1'b1;
            row_id  = row_t'(2*k);
         end
         if (y_ext == base + ycalc_t'(num_tiles_y_p + k)) begin
            is_dram = 1'b1;
            row_id  = row_t'(2*k + 1);
         end
      end
   end

   assign is_tile = (y_ext >= base) && (y_ext < base + ycalc_t'(num_tiles_y_p));

   always_comb begin
      if (px != pod_x_i)
         kind_d = e_npa_invalid;
      else if (is_dram)
         kind_d = e_npa_dram;
      else if (is_tile)
         kind_d = e_npa_global;
      else
         kind_d = e_npa_invalid;
   end

   logic [s1_width_lp-1:0]    s1_q;
   logic [1:0]                s1_kind;
   row_t                      s1_row;
   logic [xs_lp-1:0]          s1_xsub;
   logic [x_cord_width_p-1:0] s1_x;
   logic [y_cord_width_p-1:0] s1_y;
   logic [addr_width_p-1:0]   s1_epa;

   bsg_dff_reset_en #(.width_p(s1_width_lp)) s1_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (ready_o & v_i),
      .data_i  ({kind_d, row_id, xsub, x_cord_i, y_cord_i, epa_i}),
      .data_o  (s1_q)
   );

   assign {s1_kind, s1_row, s1_xsub, s1_x, s1_y, s1_epa} = s1_q;

   logic [31:0] dram_eva;
   logic        dram_overflow;

   bsg_manycore_dram_hash_inverse #(
      .addr_width_p         (addr_width_p),
      .row_width_p          (rw_lp),
      .xsub_width_p         (xs_lp),
      .block_offset_width_p (wo_lp)
   ) hash_inv (
      .row_id_i   (s1_row),
      .xsub_i     (s1_xsub),
      .epa_i      (s1_epa),
      .eva_o      (dram_eva),
      .overflow_o (dram_overflow)
   );

   bsg_manycore_global_addr_s gaddr;
   logic                      global_overflow;

   always_comb begin
      gaddr          = '0;
      gaddr.remote   = 2'b01;
      gaddr.y_cord   = max_global_y_cord_width_gp'(s1_y);
      gaddr.x_cord   = max_global_x_cord_width_gp'(s1_x);
      gaddr.addr     = global_epa_word_addr_width_gp'(s1_epa);
      gaddr.low_bits = 2'b00;
   end

   assign global_overflow = ((s1_x >> max_global_x_cord_width_gp) != '0)
                          | ((s1_y >> max_global_y_cord_width_gp) != '0)
                          | ((s1_epa >> global_epa_word_addr_width_gp) != '0);

   logic [1:0]  s2_kind_d;
   logic [31:0] s2_eva_d;

   // Anything that cannot be expressed as an EVA collapses to kind 3 with a zero address.
   always_comb begin
      s2_kind_d = e_npa_invalid;
      s2_eva_d  = '0;
      if ((s1_kind == e_npa_dram) && !dram_overflow) begin
         s2_kind_d = e_npa_dram;
         s2_eva_d  = dram_eva;
      end else if ((s1_kind == e_npa_global) && !global_overflow) begin
         s2_kind_d = e_npa_global;
         s2_eva_d  = gaddr;
      end
   end

   bsg_dff_reset_en #(.width_p(s2_width_lp)) s2_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (s2_adv & s1_v),
      .data_i  ({s2_kind_d, s2_eva_d}),
      .data_o  ({kind_o, eva_o})
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         if (ready_o) s1_v <= v_i;
         if (s2_adv)  s2_v <= s1_v;
      end
   end

   logic [15:0] invalid_count_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         invalid_count_q <= '0;
      else if (v_o && yumi_i && (kind_o == e_npa_invalid) && (invalid_count_q != 16'hFFFF))
         invalid_count_q <= invalid_count_q + 16'd1;
   end

   assign invalid_count_o = invalid_count_q;

endmodule
